apb_master_ctrl: RTL and testbench
==================================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter NUM_DEV, default 16: number of APB slaves; PSEL width.
REQ-002 Parameter TIMEOUT, default 15: maximum ACCESS cycles waiting for PREADY before abort.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 req_valid  input  1  core requests an APB transfer.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_device  input  4  target slave index, from the decoder's apb_device field.
REQ-009 req_addr  input  8  register address, from the decoder's apb_addr field.
REQ-010 req_wdata  input  8  write data, from the decoder's apb_data field.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  PSLVERR, timeout or bad device; valid with rsp_valid.
REQ-014 PSEL  output  NUM_DEV  one-hot slave select.
REQ-015 PENABLE  output  1  APB access phase.
REQ-016 PWRITE  output  1  APB direction.
REQ-017 PADDR  output  8  APB address.
REQ-018 PWDATA  output  8  APB write data.
REQ-019 PRDATA  input  8  APB read data.
REQ-020 PREADY  input  1  slave ready.
REQ-021 PSLVERR  input  1  slave error.

Function
REQ-022 States: IDLE, SETUP, ACCESS, ERRRSP; req_ready = 1 only in IDLE.
REQ-023 Acceptance: req_valid and req_ready at a clock edge; latch write, device, addr and wdata.
REQ-024 On acceptance with req_device < NUM_DEV, go to SETUP: PSEL[device]=1, PENABLE=0, PADDR/PWRITE/PWDATA drive the latched values.
REQ-025 On acceptance with req_device >= NUM_DEV, go to ERRRSP with PSEL all 0 and no APB phase.
REQ-026 ERRRSP lasts one cycle, then IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-027 SETUP lasts exactly one cycle, then ACCESS with PENABLE=1 and the wait counter cleared to 0.
REQ-028 In ACCESS with PREADY=1, transfer completes at that edge and the state returns to IDLE:
  - PSEL=0, PENABLE=0.
  - Next cycle: rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA for reads, 0 for writes.
REQ-029 In ACCESS with PREADY=0, the wait counter increments.
REQ-030 Timeout: counter == TIMEOUT-1 with PREADY=0 aborts to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0; minimum ACCESS length 1 cycle, maximum TIMEOUT cycles.
REQ-031 PSEL, PADDR, PWRITE and PWDATA are held stable from SETUP through the last ACCESS cycle; PWDATA is 0 for reads.
REQ-032 rsp_valid is high for exactly one cycle per accepted request; req_ready is also high in that cycle, so back-to-back requests are accepted.
REQ-033 Minimum transfer period is 3 cycles: accept, SETUP, ACCESS.
REQ-034 Counter width is clog2(TIMEOUT)+1 bits and does not wrap.

Reset
REQ-035 While rst_n=0, immediately and regardless of state:
  - state = IDLE; req_ready = 1.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0.
  - Counter and latches cleared.
REQ-036 A transfer interrupted by reset is dropped with no response.

Structure
REQ-037 Package apb_pkg holds the state enum, the 8-bit address/data width constants and the TIMEOUT default.
REQ-038 The wait counter is sub-module apb_wdt, with inputs clear and enable and output expired.

Verification
REQ-039 Write: dev 3, addr 0x12, data 0xA5, PREADY tied high -> PSEL=0x0008; SETUP then ACCESS; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
REQ-040 Read: dev 0, addr 0x40, PRDATA=0x5C, PREADY low for 4 ACCESS cycles -> PADDR stable for 6 cycles; rsp_rdata=0x5C, rsp_err=0.
REQ-041 Timeout: PREADY held low, TIMEOUT=15 -> abort after 15 ACCESS cycles; rsp_err=1, rsp_rdata=0; req_ready returns high.
REQ-042 Slave error: PSLVERR=1 with PREADY=1 -> rsp_err=1; next request accepted in the rsp_valid cycle.
REQ-043 Bad device: NUM_DEV=8, dev 9 -> PSEL stays 0; rsp_valid, rsp_err=1 two cycles after accept.
REQ-044 Reset in ACCESS: rst_n low mid-wait -> all APB outputs 0 at once; no rsp_valid; a new transfer after release completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master controller.
// Holds the controller state encoding, the APB address/data/device-index
// widths and the default ACCESS-phase timeout.
package apb_pkg;

   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned DEV_W       = 4;
   localparam int unsigned TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_ERRRSP
   } state_e;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bundle of the core request/response handshake and the APB bus.
//   master modport : controller view (drives req_ready, rsp_*, P* outputs)
//   slave modport  : core + APB slave view (drives requests and PRDATA/PREADY/PSLVERR)
// NUM_DEV sets the PSEL width and must match the controller's NUM_DEV.
interface apb_master_ctrl_if
   import apb_pkg::*;
#(
   parameter int unsigned NUM_DEV = 16
);

   // core request / response
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [DEV_W-1:0]  req_device;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   // APB bus
   logic [NUM_DEV-1:0] PSEL;
   logic               PENABLE;
   logic               PWRITE;
   logic [ADDR_W-1:0]  PADDR;
   logic [DATA_W-1:0]  PWDATA;
   logic [DATA_W-1:0]  PRDATA;
   logic               PREADY;
   logic               PSLVERR;

   modport master (
      input  req_valid, req_write, req_device, req_addr, req_wdata,
      input  PRDATA, PREADY, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_device, req_addr, req_wdata,
      output PRDATA, PREADY, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

endinterface

// File: rtl/apb_master_ctrl_wdt.sv
// ACCESS-phase wait counter for the APB master controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count to 0 (held outside ACCESS)
//   enable     : count one more wait cycle (ACCESS with PREADY low)
//   expired    : count has reached TIMEOUT-1; the current ACCESS cycle is the last allowed
// The count saturates at TIMEOUT-1 and never wraps.
module apb_wdt #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] cnt_q;

   assign expired = (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master controller: turns one core request into one APB transfer
// (SETUP then one or more ACCESS cycles) and returns a one-cycle response.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake and APB bus (master modport)
// Requests to a device index >= NUM_DEV skip the bus and return an error.
// ACCESS is aborted with an error after TIMEOUT cycles without PREADY.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int unsigned NUM_DEV = 16,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   apb_master_ctrl_if.master  bus
);

   state_e state_q, state_d;

   logic              write_q;
   logic [DEV_W-1:0]  dev_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   logic accept;
   logic dev_ok;
   logic sel_active;
   logic expired;

   assign dev_ok     = (32'(bus.req_device) < NUM_DEV);
   assign accept     = (state_q == ST_IDLE) && bus.req_valid;
   assign sel_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

   // Counter is held clear outside ACCESS, so it starts at 0 on the first ACCESS cycle.
   apb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_q != ST_ACCESS),
      .enable  ((state_q == ST_ACCESS) && !bus.PREADY),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_d = dev_ok ? ST_SETUP : ST_ERRRSP;
            end
         end
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (bus.PREADY || expired) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERRRSP: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Request latches; PWDATA is forced to 0 for reads at capture time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q <= 1'b0;
         dev_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         write_q <= bus.req_write;
         dev_q   <= bus.req_device;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_write ? bus.req_wdata : '0;
      end
   end

   // Response is registered so it appears in the IDLE cycle after completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         case (state_q)
            ST_ACCESS: begin
               if (bus.PREADY) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= bus.PSLVERR;
                  rsp_rdata_q <= (!write_q && !bus.PSLVERR) ? bus.PRDATA : '0;
               end else if (expired) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
               end
            end
            ST_ERRRSP: begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   assign bus.PSEL    = sel_active ? (NUM_DEV'(1) << dev_q) : '0;
   assign bus.PENABLE = (state_q == ST_ACCESS);
   assign bus.PWRITE  = write_q;
   assign bus.PADDR   = addr_q;
   assign bus.PWDATA  = wdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

   localparam int unsigned NDEV = 8;
   localparam int unsigned TMO  = 15;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   apb_master_ctrl_if #(.NUM_DEV(NDEV)) bus ();

   apb_master_ctrl #(.NUM_DEV(NDEV), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic       err;
      logic [7:0] rdata;
      int         acc_cyc;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // slave model controls / expected bus values for the transfer in flight
   int         wait_n   = 0;      // ACCESS cycles with PREADY low before PREADY high; -1 = never
   logic [7:0] exp_psel = '0;
   logic [7:0] exp_addr = '0;
   logic       exp_write = 1'b0;
   logic [7:0] exp_wdata = '0;
   int         sel_cnt  = 0;
   int         last_sel = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // APB slave model + bus-phase checker
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         sel_cnt    = 0;
         bus.PREADY = 1'b0;
      end else if (bus.PSEL !== '0) begin
         chk("psel", bus.PSEL, exp_psel);
         chk("paddr", bus.PADDR, exp_addr);
         chk("pwrite", bus.PWRITE, exp_write);
         chk("pwdata", bus.PWDATA, exp_wdata);
         chk("penable", bus.PENABLE, (sel_cnt != 0));
         bus.PREADY = (sel_cnt != 0) && (wait_n >= 0) && ((sel_cnt - 1) >= wait_n);
         sel_cnt++;
      end else begin
         chk("penable_idle", bus.PENABLE, 1'b0);
         if (sel_cnt != 0) last_sel = sel_cnt;
         sel_cnt    = 0;
         bus.PREADY = 1'b0;
      end
   end

   // response monitor / scoreboard
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
         chk("ready_in_rsp", bus.req_ready, 1'b1);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_err"}, bus.rsp_err, e.err);
            chk({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
            chk({e.tag, "_latency"}, cyc - e.acc_cyc, e.lat);
         end
      end
   end

   // Call at a negedge; returns at the negedge after acceptance.
   task automatic issue(input string tag, input logic w, input logic [3:0] dev,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] psel, input logic [7:0] pwd,
                        input logic e_err, input logic [7:0] e_rd, input int lat,
                        input bit push, output int waited);
      exp_t e;
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_device = dev;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      waited = 0;
      while (bus.req_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (bus.req_ready !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_accept: req_ready never rose within 50 cycles", tag);
         bus.req_valid = 1'b0;
         return;
      end
      exp_psel  = psel;
      exp_addr  = a;
      exp_write = w;
      exp_wdata = pwd;
      if (push) begin
         e.tag = tag; e.err = e_err; e.rdata = e_rd; e.acc_cyc = cyc; e.lat = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_device = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
   endtask

   task automatic wait_rsp(input string tag);
      int k = 0;
      while (bus.rsp_valid !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (bus.rsp_valid !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_rsp_wait: rsp_valid not seen within 60 cycles", tag);
      end
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int k;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_device = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.PRDATA     = '0;
      bus.PSLVERR    = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_err",   bus.rsp_err, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
      chk("rst_psel",      bus.PSEL, 8'h00);
      chk("rst_penable",   bus.PENABLE, 1'b0);
      chk("rst_pwrite",    bus.PWRITE, 1'b0);
      chk("rst_paddr",     bus.PADDR, 8'h00);
      chk("rst_pwdata",    bus.PWDATA, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // write, zero wait states; PRDATA garbage must not leak into rsp_rdata
      wait_n = 0; bus.PSLVERR = 1'b0; bus.PRDATA = 8'h99;
      issue("wr_d3", 1'b1, 4'd3, 8'h12, 8'hA5, 8'h08, 8'hA5, 1'b0, 8'h00, 3, 1'b1, w);
      wait_rsp("wr_d3");
      @(negedge clk);
      chk("wr_d3_sel_cycles", last_sel, 2);

      // read, four wait states
      wait_n = 4; bus.PRDATA = 8'h5C;
      issue("rd_d0", 1'b0, 4'd0, 8'h40, 8'hFF, 8'h01, 8'h00, 1'b0, 8'h5C, 7, 1'b1, w);
      wait_rsp("rd_d0");
      @(negedge clk);
      chk("rd_d0_sel_cycles", last_sel, 6);

      // timeout: PREADY never rises
      wait_n = -1; bus.PRDATA = 8'hEE;
      issue("tmo_d2", 1'b0, 4'd2, 8'h33, 8'h00, 8'h04, 8'h00, 1'b1, 8'h00, 17, 1'b1, w);
      wait_rsp("tmo_d2");
      @(negedge clk);
      chk("tmo_d2_sel_cycles", last_sel, 16);

      // slave error on highest valid device, then back-to-back read in the rsp cycle
      wait_n = 0; bus.PSLVERR = 1'b1; bus.PRDATA = 8'h42;
      issue("slverr_d7", 1'b1, 4'd7, 8'h01, 8'hFF, 8'h80, 8'hFF, 1'b1, 8'h00, 3, 1'b1, w);
      wait_rsp("slverr_d7");
      bus.PSLVERR = 1'b0; bus.PRDATA = 8'h96;
      issue("b2b_d1", 1'b0, 4'd1, 8'h80, 8'h00, 8'h02, 8'h00, 1'b0, 8'h96, 3, 1'b1, w);
      chk("b2b_accept_wait", w, 0);
      wait_rsp("b2b_d1");
      @(negedge clk);

      // bad devices: first out-of-range index and a far one
      bus.PRDATA = 8'h11;
      issue("bad_d8", 1'b0, 4'd8, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 2, 1'b1, w);
      wait_rsp("bad_d8");
      @(negedge clk);
      issue("bad_d9", 1'b1, 4'd9, 8'h20, 8'h5A, 8'h00, 8'h5A, 1'b1, 8'h00, 2, 1'b1, w);
      wait_rsp("bad_d9");
      @(negedge clk);

      // reset in the middle of an ACCESS wait; transfer must vanish without a response
      wait_n = -1;
      issue("rst_mid", 1'b1, 4'd5, 8'h77, 8'h3C, 8'h20, 8'h3C, 1'b0, 8'h00, 0, 1'b0, w);
      k = 0;
      while (sel_cnt < 4 && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk("rst_mid_in_access", bus.PENABLE, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_psel",      bus.PSEL, 8'h00);
      chk("rst_mid_penable",   bus.PENABLE, 1'b0);
      chk("rst_mid_pwrite",    bus.PWRITE, 1'b0);
      chk("rst_mid_paddr",     bus.PADDR, 8'h00);
      chk("rst_mid_pwdata",    bus.PWDATA, 8'h00);
      chk("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_mid_req_ready", bus.req_ready, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // transfer after reset release completes normally
      wait_n = 1; bus.PRDATA = 8'h00;
      issue("post_rst_d4", 1'b1, 4'd4, 8'h5A, 8'hC3, 8'h10, 8'hC3, 1'b0, 8'h00, 4, 1'b1, w);
      wait_rsp("post_rst_d4");
      repeat (3) @(negedge clk);
      chk("post_rst_sel_cycles", last_sel, 3);

      chk("sb_empty", sb.size(), 0);
      summary();
      $finish;
   end

endmodule
